ar_tag_remap_unit: RTL and testbench
====================================

// Module: ar_tag_remap_unit
// PURPOSE
// - AR-path front stage of the ROB: accepts AXI AR requests from the master.
// - Allocates a free internal tag per request, records {orig ID, LEN} in a tag table,
//   and forwards the AR with ID replaced by the tag.
// - Feeds the 8-entry outgoing AR request buffer directly.
// - The R-path reorder logic reads the table by tag and returns tags on burst completion.
// PARAMETERS
// - ID_WIDTH     4   AXI ID width, upstream and downstream
// - ADDR_WIDTH   32  AR address width
// - LEN_WIDTH    8   AR burst length width
// - SIZE_WIDTH   3   AR size width
// - BURST_WIDTH  2   AR burst type width
// - QOS_WIDTH    4   AR QoS width
// - NUM_TAGS     8   tag pool size; 2 <= NUM_TAGS <= 2**ID_WIDTH
//                    TAG_W = $clog2(NUM_TAGS), CNT_W = $clog2(NUM_TAGS+1)
// PORTS
// - clk          in   1           clock
// - rst          in   1           reset, asynchronous, active-high
// - in_valid     in   1           upstream AR valid
// - in_ready     out  1           upstream AR ready
// - in_id/addr/len/size/burst/qos  in   *_WIDTH  upstream AR fields
// - out_valid    out  1           downstream AR valid (to outgoing buffer)
// - out_ready    in   1           downstream AR ready
// - out_id       out  ID_WIDTH    allocated tag, zero-extended
// - out_addr/len/size/burst/qos    out  *_WIDTH  registered copies of accepted fields
// - rel_valid    in   1           tag release pulse from R path; no ready
// - rel_tag      in   TAG_W       tag being released
// - lk_tag       in   TAG_W       table lookup index
// - lk_orig_id   out  ID_WIDTH    orig ID stored at lk_tag; combinational
// - lk_len       out  LEN_WIDTH   LEN stored at lk_tag; combinational
// - free_cnt     out  CNT_W       number of free tags
// - rel_err      out  1           sticky: a release hit a tag that was not busy
// BEHAVIOUR
// - State: busy[NUM_TAGS] bitmap; table[NUM_TAGS] of {orig_id, len}; one output holding register.
// - Reset values: busy = 0, out_valid = 0, free_cnt = NUM_TAGS, rel_err = 0.
//   All out_* data fields = 0. Table contents are don't-care.
// - have_free = |(~busy).
// - Allocation: sel = lowest-index tag with busy = 0 (priority encoder, index 0 wins).
// - in_ready = have_free & (~out_valid | out_ready). Combinational; does not depend on in_valid.
// - accept = in_valid & in_ready. On accept, at the next edge:
//   - busy[sel] <= 1; table[sel] <= {in_id, in_len}
//   - holding register <= fields, with out_id = sel; out_valid <= 1
// - Latency: 1 cycle from accept to out_valid.
// - Back-to-back: full throughput while tags remain and out_ready = 1.
// - out_valid & ~out_ready: all out_* fields held stable; in_ready = 0.
// - out_valid & out_ready & ~accept: out_valid <= 0.
// - Release: rel_valid clears busy[rel_tag] at the next edge.
//   - If busy[rel_tag] was already 0: busy unchanged, free_cnt unchanged, rel_err <= 1 (sticky until rst).
// - Same-cycle accept and release:
//   - sel is computed from pre-release busy, so a released tag is reusable only from the next cycle.
//   - free_cnt net change = 0.
// - rel_tag >= NUM_TAGS: ignored and sets rel_err.
// - free_cnt: +1 on valid release, -1 on accept; never wraps. Equals NUM_TAGS - popcount(busy) at all times.
// - Pool exhausted (free_cnt = 0): in_ready = 0; the held request stays pending with no loss.
// - Async rst mid-burst: all tags freed; any pending out_valid is dropped.
// CONFIGURATION
// - AR_REMAP_STALL_CNT_EN defined:
//   - Adds output stall_cnt[15:0], reset 0.
//   - Increments each cycle where in_valid & ~have_free; saturates at 16'hFFFF.
// - AR_REMAP_STALL_CNT_EN undefined: the port and counter do not exist. Behaviour is otherwise identical.
// TESTING
// - Reset, then one AR (id=4'h5, len=3) with out_ready=1
//   -> out_valid the next cycle; out_id=0, lk_orig_id[0]=5, lk_len[0]=3, free_cnt=7.
// - 8 ARs back-to-back, out_ready=1, no release
//   -> out_id sequence 0..7; in_ready=0 on the 9th; free_cnt=0.
// - Pool full; rel_tag=3 pulse
//   -> next cycle in_ready=1; the following AR gets out_id=3; free_cnt returns to 0.
// - out_ready=0 for 5 cycles while in_valid=1
//   -> out_* stable; exactly 1 accept; in_ready=0 for the whole stall.
// - rel_tag=6 while tag 6 is free
//   -> rel_err=1 and stays 1; free_cnt unchanged.
// - Same cycle: accept with tag 0 free, and release of busy tag 2
//   -> accept gets tag 0; free_cnt unchanged.
//   With AR_REMAP_STALL_CNT_EN: stall_cnt counts only the exhausted-pool cycles.

Source files
------------

// File: rtl/ar_tag_remap_unit.sv
// ar_tag_remap_unit
//   AR-path front stage of the reorder buffer. Every accepted AXI AR request
//   is given the lowest-numbered free internal tag. Its original {ID, LEN} is
//   stored in a tag table indexed by that tag, and the request is forwarded
//   with its ID replaced by the tag (zero-extended).
//   The R-path reads the table via lk_tag_i and returns tags via rel_*.
//
// Configuration macro:
//   AR_REMAP_STALL_CNT_EN - adds stall_cnt_o, a saturating count of cycles
//                           where a request waits because no tag is free.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid_i/ready_o  upstream AR handshake; in_* are the AR fields
//   out_valid_o/ready_i downstream AR handshake; out_* are registered fields
//   rel_valid_i/tag_i   tag release pulse from the R path (no ready)
//   lk_tag_i            table lookup index; lk_orig_id_o / lk_len_o are
//                       combinational reads of that entry
//   free_cnt_o          number of free tags
//   rel_err_o           sticky: a release named a tag that was not busy
//   stall_cnt_o         (optional) exhausted-pool stall cycles, saturating
module ar_tag_remap_unit #(
   parameter int ID_WIDTH    = 4,
   parameter int ADDR_WIDTH  = 32,
   parameter int LEN_WIDTH   = 8,
   parameter int SIZE_WIDTH  = 3,
   parameter int BURST_WIDTH = 2,
   parameter int QOS_WIDTH   = 4,
   parameter int NUM_TAGS    = 8,
   parameter int TAG_W       = $clog2(NUM_TAGS),
   parameter int CNT_W       = $clog2(NUM_TAGS + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [ID_WIDTH-1:0]    in_id_i,
   input  logic [ADDR_WIDTH-1:0]  in_addr_i,
   input  logic [LEN_WIDTH-1:0]   in_len_i,
   input  logic [SIZE_WIDTH-1:0]  in_size_i,
   input  logic [BURST_WIDTH-1:0] in_burst_i,
   input  logic [QOS_WIDTH-1:0]   in_qos_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [ID_WIDTH-1:0]    out_id_o,
   output logic [ADDR_WIDTH-1:0]  out_addr_o,
   output logic [LEN_WIDTH-1:0]   out_len_o,
   output logic [SIZE_WIDTH-1:0]  out_size_o,
   output logic [BURST_WIDTH-1:0] out_burst_o,
   output logic [QOS_WIDTH-1:0]   out_qos_o,
   input  logic                   rel_valid_i,
   input  logic [TAG_W-1:0]       rel_tag_i,
   input  logic [TAG_W-1:0]       lk_tag_i,
   output logic [ID_WIDTH-1:0]    lk_orig_id_o,
   output logic [LEN_WIDTH-1:0]   lk_len_o,
`ifdef AR_REMAP_STALL_CNT_EN
   output logic [15:0]            stall_cnt_o,
`endif
   output logic [CNT_W-1:0]       free_cnt_o,
   output logic                   rel_err_o
);

   logic [NUM_TAGS-1:0]  busy_q, busy_d;
   logic [ID_WIDTH-1:0]  tbl_id_q  [NUM_TAGS];
   logic [LEN_WIDTH-1:0] tbl_len_q [NUM_TAGS];
   logic [CNT_W-1:0]     free_cnt_q, free_cnt_d;
   logic                 rel_err_q, rel_err_d;
   logic                 out_valid_q;

   logic                 have_free_s;
   logic [TAG_W-1:0]     sel_s;
   logic                 accept_s;
   logic                 rel_busy_s;
   logic                 rel_hit_s;

   // Priority encoder: scanning downward lets the lowest free index win last.
   always_comb begin
      have_free_s = 1'b0;
      sel_s       = '0;
      for (int i = NUM_TAGS - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            have_free_s = 1'b1;
            sel_s       = TAG_W'(i);
         end else begin
            have_free_s = have_free_s;
         end
      end
   end

   assign in_ready_o = have_free_s & (~out_valid_q | out_ready_i);
   assign accept_s   = in_valid_i & in_ready_o;

   // Busy bit of the released tag; a tag number outside the pool matches nothing and reads as free.
   always_comb begin
      rel_busy_s = 1'b0;
      for (int i = 0; i < NUM_TAGS; i++) begin
         if (rel_tag_i == TAG_W'(i)) begin
            rel_busy_s = busy_q[i];
         end else begin
            rel_busy_s = rel_busy_s;
         end
      end
   end

   assign rel_hit_s = rel_valid_i & rel_busy_s;

   // Next busy map, free count and error flag. The allocated tag is free and the
   // released tag busy, so the two updates never touch the same bit.
   always_comb begin
      busy_d = busy_q;
      if (rel_hit_s) begin
         busy_d[rel_tag_i] = 1'b0;
      end else begin
         busy_d = busy_d;
      end
      if (accept_s) begin
         busy_d[sel_s] = 1'b1;
      end else begin
         busy_d = busy_d;
      end
      free_cnt_d = free_cnt_q + CNT_W'(rel_hit_s) - CNT_W'(accept_s);
      rel_err_d  = rel_err_q | (rel_valid_i & ~rel_busy_s);
   end

   // Tag bookkeeping registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q     <= '0;
         free_cnt_q <= CNT_W'(NUM_TAGS);
         rel_err_q  <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         free_cnt_q <= free_cnt_d;
         rel_err_q  <= rel_err_d;
      end
   end

   // Output holding register: load on accept, drop valid once consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_id_o    <= '0;
         out_addr_o  <= '0;
         out_len_o   <= '0;
         out_size_o  <= '0;
         out_burst_o <= '0;
         out_qos_o   <= '0;
      end else if (accept_s) begin
         out_valid_q <= 1'b1;
         out_id_o    <= ID_WIDTH'(sel_s);
         out_addr_o  <= in_addr_i;
         out_len_o   <= in_len_i;
         out_size_o  <= in_size_i;
         out_burst_o <= in_burst_i;
         out_qos_o   <= in_qos_i;
      end else if (out_ready_i) begin
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= out_valid_q;
      end
   end

   // Tag table; contents are meaningful only while the tag is busy, so no reset.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         tbl_id_q[sel_s]  <= in_id_i;
         tbl_len_q[sel_s] <= in_len_i;
      end else begin
         tbl_id_q[sel_s]  <= tbl_id_q[sel_s];
         tbl_len_q[sel_s] <= tbl_len_q[sel_s];
      end
   end

   // Combinational table read; an index outside the pool reads zero.
   always_comb begin
      lk_orig_id_o = '0;
      lk_len_o     = '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
         if (lk_tag_i == TAG_W'(i)) begin
            lk_orig_id_o = tbl_id_q[i];
            lk_len_o     = tbl_len_q[i];
         end else begin
            lk_len_o = lk_len_o;
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign free_cnt_o  = free_cnt_q;
   assign rel_err_o   = rel_err_q;

`ifdef AR_REMAP_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   // Saturating count of cycles where a request waits on an exhausted pool.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= 16'h0000;
      end else if (in_valid_i && !have_free_s && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'h0001;
      end else begin
         stall_cnt_q <= stall_cnt_q;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ar_tag_remap_unit.sv
// Self-checking bench for ar_tag_remap_unit: a directed vector table with
// hand-computed expectations, hand-written stall and async-reset sequences,
// and a randomized phase, all checked against a tag-pool model.
module tb_ar_tag_remap_unit;

   localparam int N = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_ready;
   logic [3:0]  in_id = 4'h0;
   logic [31:0] in_addr = 32'h0;
   logic [7:0]  in_len = 8'h0;
   logic [2:0]  in_size = 3'h0;
   logic [1:0]  in_burst = 2'h0;
   logic [3:0]  in_qos = 4'h0;
   logic        out_valid, out_ready = 1'b0;
   logic [3:0]  out_id;
   logic [31:0] out_addr;
   logic [7:0]  out_len;
   logic [2:0]  out_size;
   logic [1:0]  out_burst;
   logic [3:0]  out_qos;
   logic        rel_valid = 1'b0;
   logic [2:0]  rel_tag = 3'h0, lk_tag = 3'h0;
   logic [3:0]  lk_orig_id;
   logic [7:0]  lk_len;
   logic [3:0]  free_cnt;
   logic        rel_err;
`ifdef AR_REMAP_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ar_tag_remap_unit dut (
      .clk(clk), .rst(rst),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_id_i(in_id), .in_addr_i(in_addr), .in_len_i(in_len),
      .in_size_i(in_size), .in_burst_i(in_burst), .in_qos_i(in_qos),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_id_o(out_id), .out_addr_o(out_addr), .out_len_o(out_len),
      .out_size_o(out_size), .out_burst_o(out_burst), .out_qos_o(out_qos),
      .rel_valid_i(rel_valid), .rel_tag_i(rel_tag),
      .lk_tag_i(lk_tag), .lk_orig_id_o(lk_orig_id), .lk_len_o(lk_len),
`ifdef AR_REMAP_STALL_CNT_EN
      .stall_cnt_o(stall_cnt),
`endif
      .free_cnt_o(free_cnt), .rel_err_o(rel_err)
   );

   // Reference model: pool of tags, table, pending forwarded request.
   bit          m_busy [N];
   bit          m_written [N];
   logic [3:0]  m_tid [N];
   logic [7:0]  m_tlen [N];
   bit          m_ov;
   logic [3:0]  m_oid;
   logic [31:0] m_oaddr;
   logic [7:0]  m_olen;
   logic [2:0]  m_osize;
   logic [1:0]  m_oburst;
   logic [3:0]  m_oqos;
   bit          m_err;
   int          m_stall;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      m_ov = 1'b0; m_oid = 4'h0; m_oaddr = 32'h0; m_olen = 8'h0;
      m_osize = 3'h0; m_oburst = 2'h0; m_oqos = 4'h0;
      m_err = 1'b0; m_stall = 0;
   endtask

   function automatic int num_free();
      int c = 0;
      for (int i = 0; i < N; i++) if (!m_busy[i]) c++;
      return c;
   endfunction

   function automatic int lowest_free();
      for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
      return -1;
   endfunction

   task automatic check_registered(input string tagn);
      chk({tagn, ".out_valid"}, 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
         chk({tagn, ".out_id"},   32'(out_id),   32'(m_oid));
         chk({tagn, ".out_addr"}, out_addr,      m_oaddr);
         chk({tagn, ".out_len"},  32'(out_len),  32'(m_olen));
         chk({tagn, ".out_misc"}, {23'h0, out_size, out_burst, out_qos},
             {23'h0, m_osize, m_oburst, m_oqos});
      end
      chk({tagn, ".free_cnt"}, 32'(free_cnt), 32'(num_free()));
      chk({tagn, ".rel_err"},  32'(rel_err),  32'(m_err));
`ifdef AR_REMAP_STALL_CNT_EN
      chk({tagn, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
`endif
   endtask

   // One clock: drive at negedge, check combinational outputs, step the model
   // across the posedge, then check registered outputs.
   task automatic cycle(input string tagn, input logic iv, input logic [3:0] id,
                        input logic [7:0] len, input logic ordy, input logic rv,
                        input logic [2:0] rt, input logic [2:0] lt, output logic rdy_seen);
      bit exp_rdy, acc, rel_ok;
      int sel;
      @(negedge clk);
      in_valid = iv; in_id = id; in_len = len; out_ready = ordy;
      in_addr = $urandom; in_size = 3'($urandom); in_burst = 2'($urandom);
      in_qos = 4'($urandom);
      rel_valid = rv; rel_tag = rt; lk_tag = lt;
      #1;
      exp_rdy = (num_free() > 0) && (!m_ov || ordy);
      rdy_seen = in_ready;
      chk({tagn, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
      if (m_written[lt]) begin
         chk({tagn, ".lk_orig_id"}, 32'(lk_orig_id), 32'(m_tid[lt]));
         chk({tagn, ".lk_len"},     32'(lk_len),     32'(m_tlen[lt]));
      end
      acc    = iv && exp_rdy;
      sel    = lowest_free();
      rel_ok = rv && (int'(rt) < N) && m_busy[rt];
      if (iv && num_free() == 0 && m_stall < 65535) m_stall++;
      if (rv && !rel_ok) m_err = 1'b1;
      if (rel_ok) m_busy[rt] = 1'b0;
      if (acc) begin
         m_busy[sel] = 1'b1; m_written[sel] = 1'b1;
         m_tid[sel] = id; m_tlen[sel] = len;
         m_ov = 1'b1; m_oid = 4'(sel); m_oaddr = in_addr; m_olen = len;
         m_osize = in_size; m_oburst = in_burst; m_oqos = in_qos;
      end else if (ordy) begin
         m_ov = 1'b0;
      end
      @(posedge clk);
      #1;
      check_registered(tagn);
   endtask

   typedef struct packed {
      logic       iv;
      logic [3:0] id;
      logic [7:0] len;
      logic       ordy;
      logic       rv;
      logic [2:0] rt;
      logic       x_rdy;
      logic       x_ov;
      logic [3:0] x_oid;
      logic [3:0] x_fc;
      logic       x_err;
   } vec_t;

   vec_t vecs [17];

   initial begin
      logic rdy;
      int   accepts;

      for (int i = 0; i < N; i++) m_written[i] = 1'b0;
      model_reset();

      // Expected values worked out by hand from the tag-pool rules.
      vecs[0] = '{1'b1, 4'h5, 8'd3, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 4'd0, 4'd7, 1'b0};
      for (int i = 1; i < 8; i++)
         vecs[i] = '{1'b1, 4'(i), 8'(i), 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 4'(i), 4'(7 - i), 1'b0};
      vecs[8]  = '{1'b1, 4'hE, 8'd1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0};
      vecs[9]  = '{1'b0, 4'h0, 8'd0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0};
      vecs[10] = '{1'b1, 4'h9, 8'd9, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 4'd3, 4'd0, 1'b0};
      vecs[11] = '{1'b0, 4'h0, 8'd0, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0};
      vecs[12] = '{1'b0, 4'h0, 8'd0, 1'b1, 1'b1, 3'd6, 1'b1, 1'b0, 4'd0, 4'd1, 1'b1};
      vecs[13] = '{1'b0, 4'h0, 8'd0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b1};
      vecs[14] = '{1'b0, 4'h0, 8'd0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 4'd0, 4'd2, 1'b1};
      vecs[15] = '{1'b1, 4'hA, 8'd4, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 4'd0, 4'd2, 1'b1};
      vecs[16] = '{1'b1, 4'hB, 8'd5, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 4'd2, 4'd1, 1'b1};

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check_registered("reset");
      chk("reset.out_id",   32'(out_id), 32'h0);
      chk("reset.out_addr", out_addr,    32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset.in_ready", 32'(in_ready), 32'h1);

      // Directed vector table.
      for (int v = 0; v < 17; v++) begin
         string nm;
         nm = $sformatf("vec%0d", v);
         cycle(nm, vecs[v].iv, vecs[v].id, vecs[v].len, vecs[v].ordy,
               vecs[v].rv, vecs[v].rt, 3'(v), rdy);
         chk({nm, ".x_rdy"}, 32'(rdy), 32'(vecs[v].x_rdy));
         chk({nm, ".x_ov"},  32'(out_valid), 32'(vecs[v].x_ov));
         if (vecs[v].x_ov) chk({nm, ".x_oid"}, 32'(out_id), 32'(vecs[v].x_oid));
         chk({nm, ".x_fc"},  32'(free_cnt), 32'(vecs[v].x_fc));
         chk({nm, ".x_err"}, 32'(rel_err), 32'(vecs[v].x_err));
      end

      // Downstream stall: drain, then 5 cycles of out_ready=0 with in_valid=1.
      cycle("drain", 1'b0, 4'h0, 8'h0, 1'b1, 1'b0, 3'd0, 3'd0, rdy);
      accepts = 0;
      for (int c = 0; c < 5; c++) begin
         cycle($sformatf("stall%0d", c), 1'b1, 4'hC, 8'd7, 1'b0, 1'b0, 3'd0, 3'd6, rdy);
         if (rdy) accepts++;
      end
      chk("stall.accepts", 32'(accepts), 32'd1);
      chk("stall.out_id",  32'(out_id),  32'd6);

      // Async reset while a request is pending downstream.
      cycle("predrop", 1'b0, 4'h0, 8'h0, 1'b0, 1'b0, 3'd0, 3'd0, rdy);
      chk("predrop.out_valid", 32'(out_valid), 32'h1);
      #3;
      rst = 1'b1;
      #1;
      chk("async.out_valid", 32'(out_valid), 32'h0);
      chk("async.free_cnt",  32'(free_cnt),  32'd8);
      chk("async.rel_err",   32'(rel_err),   32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cycle("postrst", 1'b1, 4'h3, 8'd2, 1'b1, 1'b0, 3'd0, 3'd0, rdy);
      chk("postrst.out_id", 32'(out_id), 32'h0);

      // Randomized traffic against the model.
      for (int c = 0; c < 400; c++) begin
         cycle("rand", ($urandom_range(0, 3) != 0), 4'($urandom), 8'($urandom),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
               3'($urandom), 3'($urandom), rdy);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
